// File: rtl/urna_pkg.sv
// Shared definitions for the voting keypad front-end and the vote FSM.
package urna_pkg;

    localparam int NUM_KEYS = 10;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StDebounce  = 3'd1,
        StHeld      = 3'd2,
        StRelease   = 3'd3,
        StWaitClear = 3'd4
    } key_state_t;

    localparam logic [3:0] DIG_0 = 4'd0;
    localparam logic [3:0] DIG_1 = 4'd1;
    localparam logic [3:0] DIG_2 = 4'd2;
    localparam logic [3:0] DIG_3 = 4'd3;
    localparam logic [3:0] DIG_4 = 4'd4;
    localparam logic [3:0] DIG_5 = 4'd5;
    localparam logic [3:0] DIG_6 = 4'd6;
    localparam logic [3:0] DIG_7 = 4'd7;
    localparam logic [3:0] DIG_8 = 4'd8;
    localparam logic [3:0] DIG_9 = 4'd9;

    // Two-digit candidate codes consumed by the vote FSM.
    localparam logic [3:0] C1_FIRST  = DIG_1;
    localparam logic [3:0] C1_SECOND = DIG_3;
    localparam logic [3:0] C2_FIRST  = DIG_2;
    localparam logic [3:0] C2_SECOND = DIG_7;

    // OR of the indices of all set bits; only meaningful when exactly one bit is set.
    function automatic logic [3:0] onehot_to_bin(input logic [NUM_KEYS-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (oh[k]) idx = idx | 4'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/urna_debounce.sv
// Level debouncer: output follows the input once it has disagreed for DEB_CYCLES cycles.
module urna_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (in == out) begin
            cnt <= '0;
        end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            out <= in;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/urna_teclado.sv
// Keypad front-end: synchronises and debounces digit keys, finish and swap switches,
// and emits one digit/valid pulse per clean single-key press.
module urna_teclado
    import urna_pkg::*;
#(
    parameter int DEB_CYCLES  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] raw_key,
    input  logic                raw_finish,
    input  logic                raw_swap,
    output logic [3:0]          digit,
    output logic                valid,
    output logic                finish,
    output logic                swap,
    output logic                key_error
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int SW = NUM_KEYS + 2;

    logic [SW-1:0]       sync_q [SYNC_STAGES];
    logic [NUM_KEYS-1:0] key_s;
    logic                fin_s;
    logic                swp_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {raw_swap, raw_finish, raw_key};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign key_s = sync_q[SYNC_STAGES-1][NUM_KEYS-1:0];
    assign fin_s = sync_q[SYNC_STAGES-1][NUM_KEYS];
    assign swp_s = sync_q[SYNC_STAGES-1][NUM_KEYS+1];

    urna_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_finish (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (fin_s),
        .out  (finish)
    );

    urna_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_swap (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (swp_s),
        .out  (swap)
    );

    key_state_t          state;
    logic [CW-1:0]       cnt;
    logic [3:0]          cand;
    logic [NUM_KEYS-1:0] cand_onehot;
    logic                single_key;
    logic                multi_key;

    assign cand_onehot = {{(NUM_KEYS-1){1'b0}}, 1'b1} << cand;
    assign single_key  = ($countones(key_s) == 1);
    assign multi_key   = ($countones(key_s) > 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            cand      <= '0;
            digit     <= '0;
            valid     <= 1'b0;
            key_error <= 1'b0;
        end else begin
            valid     <= 1'b0;
            key_error <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (single_key) begin
                        cand  <= onehot_to_bin(key_s);
                        cnt   <= CW'(1);
                        state <= StDebounce;
                    end else if (multi_key) begin
                        key_error <= 1'b1;
                        state     <= StWaitClear;
                    end
                end
                StDebounce: begin
                    if (key_s == cand_onehot) begin
                        if (cnt == CW'(DEB_CYCLES)) begin
                            // Presses accepted while voting is finished are swallowed.
                            if (!finish) begin
                                valid <= 1'b1;
                                digit <= cand;
                            end
                            cnt   <= '0;
                            state <= StHeld;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        cnt   <= '0;
                        state <= StIdle;
                    end
                end
                StHeld, StWaitClear: begin
                    if (key_s == '0) begin
                        cnt   <= CW'(1);
                        state <= StRelease;
                    end
                end
                StRelease: begin
                    if (key_s != '0) begin
                        cnt <= CW'(1);
                    end else if (cnt == CW'(DEB_CYCLES)) begin
                        cnt   <= '0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
